d_to_sr_ff: RTL and testbench

D_TO_SR_FF -- requirements
Module: d_to_sr_ff

---
 rtl/d_to_sr_ff_pkg.sv | 15 +
 rtl/d_ff.sv | 29 ++
 rtl/d_to_sr_ff.sv | 31 +++
 tb/tb_d_to_sr_ff.sv | 126 ++++++++++++
 4 files changed

// File: rtl/d_to_sr_ff_pkg.sv
// rtl/d_to_sr_ff_pkg.sv - shared constants for the S/R flip-flop
// Contents: Q reset value and the {S,R} command encodings.
package d_to_sr_ff_pkg;

  localparam logic Q_RST_VAL = 1'b0;

  // {S,R} command encodings; both asserted is defined as set-dominant.
  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_CLR     = 2'b01,
    SR_SET     = 2'b10,
    SR_SET_DOM = 2'b11
  } sr_cmd_e;

endpackage

// File: rtl/d_ff.sv
// rtl/d_ff.sv - 1-bit D flip-flop with synchronous active-high reset
// Ports: clk (clock), rst (sync reset, active high), d (data in), q (registered out).
module d_ff
  import d_to_sr_ff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= Q_RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/d_to_sr_ff.sv
// rtl/d_to_sr_ff.sv - set-dominant SR flip-flop built from a D flip-flop
// Ports: clk (clock), rst (sync reset, active high), S (set), R (clear), Q (registered state).
module d_to_sr_ff
  import d_to_sr_ff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q
);

  logic q_d;
  logic q_q;

  // Set wins over clear; otherwise hold unless cleared.
  always_comb begin
    q_d = S | (~R & q_q);
  end

  d_ff u_d_ff (
    .clk (clk),
    .rst (rst),
    .d   (q_d),
    .q   (q_q)
  );

  // Q comes straight from the flop, so S/R never reach it combinationally.
  assign Q = q_q;

endmodule

// File: tb/tb_d_to_sr_ff.sv
// tb/tb_d_to_sr_ff.sv - self-checking bench for d_to_sr_ff
module tb_d_to_sr_ff;
  import d_to_sr_ff_pkg::*;

  logic clk;
  logic rst;
  logic S;
  logic R;
  logic Q;

  int n_cmp;
  int n_bad;

  logic model_q;
  logic model_valid;

  d_to_sr_ff dut (
    .clk (clk),
    .rst (rst),
    .S   (S),
    .R   (R),
    .Q   (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: command table applied once per rising edge, reset overriding all.
  initial begin
    model_q     = 1'b0;
    model_valid = 1'b0;
  end

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (rst) begin
      model_q <= 1'b0;
    end else begin
      case (sr_cmd_e'({S, R}))
        SR_HOLD:    model_q <= model_q;
        SR_CLR:     model_q <= 1'b0;
        SR_SET:     model_q <= 1'b1;
        SR_SET_DOM: model_q <= 1'b1;
        default:    model_q <= 1'bx;
      endcase
    end
  end

  // Every falling edge after the first reset edge: DUT must track the model.
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp = n_cmp + 1;
      if (Q !== model_q) begin
        n_bad = n_bad + 1;
        $display("FAIL model_track t=%0t Q=%b expected=%b", $time, Q, model_q);
      end
    end
  end

  task automatic at_time(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string name, input logic exp);
    n_cmp = n_cmp + 1;
    if (Q !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s t=%0t Q=%b expected=%b", name, $time, Q, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    S   = 1'b0;
    R   = 1'b0;

    at_time(8);   check("reset_state", 1'b0);
    at_time(12);  rst = 1'b0;
    at_time(18);  check("first_edge_after_reset", 1'b0);

    at_time(22);  S = 1'b1;
    at_time(28);  check("set", 1'b1);
    S = 1'b0;
    at_time(38);  check("hold_high_1", 1'b1);
    at_time(48);  check("hold_high_2", 1'b1);

    R = 1'b1;
    at_time(58);  check("clear", 1'b0);
    R = 1'b0;
    at_time(68);  check("hold_low", 1'b0);

    S = 1'b1; R = 1'b1;
    at_time(78);  check("set_dominant", 1'b1);

    R = 1'b0;
    at_time(88);  check("set_before_rst", 1'b1);
    rst = 1'b1;
    at_time(92);  check("rst_not_yet_applied", 1'b1);
    at_time(98);  check("rst_priority", 1'b0);
    at_time(108); check("rst_held", 1'b0);
    rst = 1'b0; S = 1'b0;

    at_time(112); S = 1'b1;
    at_time(113); S = 1'b0;
    at_time(118); check("glitch_ignored", 1'b0);

    S = 1'b1;
    at_time(138); check("set_idempotent", 1'b1);
    S = 1'b0; R = 1'b1;
    at_time(158); check("clear_idempotent", 1'b0);

    S = 1'b1; R = 1'b0;
    at_time(168); check("set_again", 1'b1);
    rst = 1'b1; S = 1'b1; R = 1'b1;
    at_time(178); check("rst_over_set_dom", 1'b0);
    rst = 1'b0;
    at_time(188); check("set_dom_after_rst", 1'b1);

    at_time(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
